rgb_adj_arbiter: RTL and testbench
==================================

Name: rgb_adj_arbiter

Overview:
- Shares one rgb_contrast_adj datapath instance among NUM_REQ pixel-stream requesters.
- Packets are arbitrated round-robin, and a grant is held until the packet's last beat.
- Each packet is passed through the adjuster with its own contrast-enable, then through a registered valid/ready output stage tagged with the source ID.
- Sits between the per-camera/DMA pixel sources and the downstream frame writer.

Parameters:
- NUM_REQ, 2, number of requesters (1..8); ID_W = max(1, $clog2(NUM_REQ)) is derived as a localparam.
- CNT_W, 16, width of the packet counter (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_ready_o  out  NUM_REQ  per-requester beat ready.
- req_last_i  in  NUM_REQ  last beat of packet.
- req_adj_en_i  in  NUM_REQ  contrast enable for the requester's packet.
- req_rgb_i  in  24*NUM_REQ  requester k at bits [24k+23:24k]; R=[23:16], G=[15:8], B=[7:0].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- out_rgb_o  out  24  adjusted pixel, same packing as the inputs.
- out_last_o  out  1  last beat of packet.
- out_id_o  out  ID_W  source requester index.
- busy_o  out  1  high while a grant is held (state LOCKED).

Behaviour:
- Reset values: state IDLE, rr pointer 0, grant 0, latched enable 0; all outputs 0, including req_ready_o.
- FSM, IDLE:
  - If any req_valid_i bit is set, pick the winner: the first valid index searching upward from the rr pointer, with wrap-around.
  - Register grant = winner and latch en = req_adj_en_i[winner]; go to LOCKED.
  - No beat is accepted in IDLE.
- FSM, LOCKED:
  - req_ready_o[grant] = slot_free, where slot_free = !out_valid_o || out_ready_i. All other ready bits are 0.
  - A beat transfers when req_valid_i[grant] && req_ready_o[grant].
  - On a transfer with req_last_i[grant]=1: go to IDLE and set rr pointer = (grant+1) mod NUM_REQ.
  - The enable latched at grant applies to the whole packet. Mid-packet changes on req_adj_en_i are ignored.
  - If valid drops mid-packet, the grant is held indefinitely (no timeout).
- Datapath:
  - Muxed pixel of the granted requester -> one rgb_contrast_adj (en_i = latched en) -> output register.
  - Per channel with en=1: x<85 -> x>>1; 85<=x<170 -> 42+2*(x-85); x>=170 -> 213+((x-170)>>1).
  - en=0 passes pixels unchanged.
- Output stage:
  - Latency is 1 cycle from an accepted beat to out_valid_o.
  - On a transfer, register rgb, last, and id = grant; out_valid_o <= 1.
  - If out_ready_i && no new transfer, out_valid_o <= 0.
  - Data is held stable while out_valid_o && !out_ready_i.
  - Full throughput (1 beat/cycle) within a packet.
- Simultaneous events: a simultaneous output drain and new beat keeps out_valid_o=1 with the new data.
- Inter-packet gap: one IDLE arbitration cycle between packets; this cost is accepted.
- Single-beat packets (valid && last on the first beat) are legal.
- NUM_REQ=1: the arbiter degenerates to always-grant-0 with the same timing.
- Reset mid-packet: the packet is aborted and out_valid_o is cleared immediately. There is no partial completion and no out_last_o is emitted.

Optional Feature:
- Macro: RGB_ADJ_ARBITER_PKT_CNT_EN.
- When defined:
  - Adds output pkt_cnt_o [CNT_W], reset 0.
  - Increments on every out_valid_o && out_ready_i && out_last_o and wraps from 2^CNT_W-1 to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Req0 sends a 3-beat packet with en=1, pixels 0x00_54_55, 0xA9_AA_FF, 0x10_20_30, out_ready_i=1 -> outputs 0x00_2A_2A, 0xD2_D5_FF, 0x08_10_18 with id=0; last on beat 3; first output 2 cycles after valid rises (arbitration + register).
- Req0 and req1 both valid with continuous 2-beat packets, pointer at 0 -> packet order 0,1,0,1; the winner never changes mid-packet; busy_o drops for exactly 1 cycle between packets.
- out_ready_i held low 4 cycles mid-packet -> out_rgb_o/out_last_o/out_id_o stable; req_ready_o[grant]=0; no beat lost or duplicated.
- req_adj_en_i[1] toggles from 0 to 1 after the first beat of a req1 packet with pixel 0x64_64_64 -> all beats output 0x64_64_64 (unadjusted).
- rst_i asserted during beat 2 of a 4-beat packet -> next edge all outputs 0, state IDLE, pointer 0; the first packet after release re-arbitrates from requester 0.
- With RGB_ADJ_ARBITER_PKT_CNT_EN and CNT_W=2: 5 completed packets -> pkt_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/rgb_adj_arbiter.sv
// rgb_adj_arbiter
//   Shares one contrast-adjust datapath among NUM_REQ pixel-stream requesters.
//   Packets are granted round-robin. A grant is held until the packet's last
//   beat has transferred. Each packet is adjusted with the contrast-enable
//   sampled when its grant was issued. The result goes to a registered
//   valid/ready output stage that is tagged with the source index.
//
// Optional build macro: RGB_ADJ_ARBITER_PKT_CNT_EN
//   When defined, this adds pkt_cnt_o[CNT_W]. It counts packets completed on
//   the output interface and wraps around.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   req_valid_i    per-requester beat valid              [NUM_REQ]
//   req_ready_o    per-requester beat ready              [NUM_REQ]
//   req_last_i     per-requester last beat of packet     [NUM_REQ]
//   req_adj_en_i   per-requester contrast enable         [NUM_REQ]
//   req_rgb_i      requester k at [24k+23:24k], R/G/B    [24*NUM_REQ]
//   out_valid_o    output beat valid
//   out_ready_i    downstream ready
//   out_rgb_o      adjusted pixel                        [24]
//   out_last_o     last beat of packet
//   out_id_o       source requester index                [ID_W]
//   busy_o         a grant is currently held
//   pkt_cnt_o      completed-packet counter (macro only) [CNT_W]
`timescale 1ns/1ps

// Per-channel piecewise contrast stretch. The middle band is expanded and
// the dark and bright bands are compressed. When en_i is low, the pixel is
// passed through unchanged.
module rgb_contrast_adj (
  input  logic        en_i,
  input  logic [23:0] rgb_i,
  output logic [23:0] rgb_o
);

  function automatic logic [7:0] adj_ch(input logic [7:0] x);
    logic [7:0] d;
    if (x < 8'd85) begin
      return x >> 1;
    end else if (x < 8'd170) begin
      d = x - 8'd85;                       // 0..84, so the doubling fits in 8 bits
      return 8'd42 + {d[6:0], 1'b0};
    end else begin
      d = x - 8'd170;                      // 0..85
      return 8'd213 + (d >> 1);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign rgb_o[gi*8 +: 8] = en_i ? adj_ch(rgb_i[gi*8 +: 8]) : rgb_i[gi*8 +: 8];
  end

endmodule

module rgb_adj_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ-1:0]     req_adj_en_i,
  input  logic [24*NUM_REQ-1:0]  req_rgb_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [23:0]            out_rgb_o,
  output logic                   out_last_o,
  output logic [ID_W-1:0]        out_id_o,
  output logic                   busy_o
`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0]       pkt_cnt_o
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              en_q, en_d;

  logic              out_valid_q;
  logic [23:0]       out_rgb_q;
  logic              out_last_q;
  logic [ID_W-1:0]   out_id_q;

  logic              locked;
  logic              slot_free;
  logic              xfer;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [ID_W-1:0]   cand;
  logic [23:0]       pix_sel;
  logic [23:0]       pix_adj;
  logic [23:0]       pix_arr [NUM_REQ];

  // Unpack the flat pixel bus so that the granted requester can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign pix_arr[gi] = req_rgb_i[gi*24 +: 24];
  end

  // This is (base + off) mod NUM_REQ. It works for non-power-of-two NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign locked    = (state_q == LOCKED);
  assign slot_free = !out_valid_q || out_ready_i;
  assign xfer      = locked && req_valid_i[grant_q] && slot_free;
  assign busy_o    = locked;

  // Round-robin pick. The scan runs downward, so the smallest offset from
  // the pointer is written last and wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = wrap_idx(rr_q, i);
      if (req_valid_i[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (locked) req_ready_o[grant_q] = slot_free;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          en_d    = req_adj_en_i[winner];
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && req_last_i[grant_q]) begin
          state_d = IDLE;
          rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
    end
  end

  assign pix_sel = pix_arr[grant_q];

  rgb_contrast_adj u_adj (
    .en_i  (en_q),
    .rgb_i (pix_sel),
    .rgb_o (pix_adj)
  );

  // Output register. A new beat may load in the same cycle as a drain, which
  // keeps valid high. Otherwise, a drain clears valid and a stall holds everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_rgb_q   <= pix_adj;
      out_last_q  <= req_last_i[grant_q];
      out_id_q    <= grant_q;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_rgb_o   = out_rgb_q;
  assign out_last_o  = out_last_q;
  assign out_id_o    = out_id_q;

`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
  logic [CNT_W-1:0] pkt_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else if (out_valid_q && out_ready_i && out_last_q) begin
      pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_rgb_adj_arbiter.sv
`timescale 1ns/1ps

module tb_rgb_adj_arbiter;

  localparam int NUM   = 3;
  localparam int CNT_W = 2;
  localparam int ID_W  = (NUM > 1) ? $clog2(NUM) : 1;

  typedef struct {
    logic [23:0] rgb;
    logic        last;
    logic        en;     // value driven on req_adj_en_i while this beat is offered
    logic        first;
  } beat_t;

  typedef struct {
    logic [23:0] rgb;
    logic        last;
    int          id;
  } obs_t;

  logic                clk;
  logic                rst_i;
  logic [NUM-1:0]      req_valid_i;
  logic [NUM-1:0]      req_ready_o;
  logic [NUM-1:0]      req_last_i;
  logic [NUM-1:0]      req_adj_en_i;
  logic [24*NUM-1:0]   req_rgb_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [23:0]         out_rgb_o;
  logic                out_last_o;
  logic [ID_W-1:0]     out_id_o;
  logic                busy_o;
`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
  logic [CNT_W-1:0]    pkt_cnt_o;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t src_q [NUM][$];
  obs_t  obs_q [$];
  bit    gap_mode = 0;

  rgb_adj_arbiter #(.NUM_REQ(NUM), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_last_i   (req_last_i),
    .req_adj_en_i (req_adj_en_i),
    .req_rgb_i    (req_rgb_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_rgb_o    (out_rgb_o),
    .out_last_o   (out_last_o),
    .out_id_o     (out_id_o),
    .busy_o       (busy_o)
`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference contrast curve, written directly from the band rules.
  function automatic logic [7:0] ref_ch(input logic [7:0] x);
    int v;
    v = int'(x);
    if (v < 85)       return 8'(v / 2);
    else if (v < 170) return 8'(42 + 2 * (v - 85));
    else              return 8'(213 + (v - 170) / 2);
  endfunction

  function automatic logic [23:0] ref_px(input logic [23:0] p, input logic en);
    if (!en) return p;
    return {ref_ch(p[23:16]), ref_ch(p[15:8]), ref_ch(p[7:0])};
  endfunction

  // One clock cycle. Inputs are driven at the negedge, and handshakes are
  // sampled just before the posedge. The task returns 1ns after the posedge.
  task automatic step(input bit rdy);
    @(negedge clk);
    out_ready_i = rdy;
    for (int k = 0; k < NUM; k++) begin
      if (src_q[k].size() > 0) begin
        req_valid_i[k]          = src_q[k][0].first || !gap_mode || ($urandom_range(3) != 0);
        req_rgb_i[k*24 +: 24]   = src_q[k][0].rgb;
        req_last_i[k]           = src_q[k][0].last;
        req_adj_en_i[k]         = src_q[k][0].en;
      end else begin
        req_valid_i[k]          = 1'b0;
        req_rgb_i[k*24 +: 24]   = 24'($urandom);
        req_last_i[k]           = 1'($urandom);
        req_adj_en_i[k]         = 1'($urandom);
      end
    end
    #1;
    if (out_valid_o && out_ready_i) obs_q.push_back('{out_rgb_o, out_last_o, int'(out_id_o)});
    for (int k = 0; k < NUM; k++)
      if (req_valid_i[k] && req_ready_o[k]) void'(src_q[k].pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int n, input int max_cyc);
    for (int c = 0; c < max_cyc && obs_q.size() < n; c++) step(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i        = 1'b1;
    req_valid_i  = '0;
    out_ready_i  = 1'b0;
    for (int k = 0; k < NUM; k++) src_q[k].delete();
    obs_q.delete();
    gap_mode = 0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic push_pkt(input int k, input int len, input logic en, input logic [23:0] px);
    for (int b = 0; b < len; b++) src_q[k].push_back('{px, b == len - 1, en, b == 0});
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    req_valid_i  = '1;
    req_last_i   = '1;
    req_adj_en_i = '1;
    req_rgb_i    = '1;
    out_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_rgb_o !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want 000000", out_rgb_o); end
    n_checks++; if (out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last_o); end
    n_checks++; if (out_id_o !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", out_id_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready_o); end
`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
    n_checks++; if (pkt_cnt_o !== '0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt_o); end
`endif
    req_valid_i = '0;
    rst_i = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic_packet();
    do_reset();
    src_q[0].push_back('{24'h005455, 1'b0, 1'b1, 1'b1});
    src_q[0].push_back('{24'hA9AAFF, 1'b0, 1'b1, 1'b0});
    src_q[0].push_back('{24'h102030, 1'b1, 1'b1, 1'b0});
    step(1'b1);  // arbitration edge
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_lock: got %b want 1", busy_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_out: got %b want 0", out_valid_o); end
    n_checks++; if (req_ready_o !== 3'b001) begin n_fail++; $display("FAIL basic_ready: got %b want 001", req_ready_o); end
    step(1'b1);
    n_checks++; if ({out_valid_o, out_rgb_o, out_last_o, 2'(out_id_o)} !== {1'b1, 24'h002A2A, 1'b0, 2'd0})
      begin n_fail++; $display("FAIL basic_beat1: got v=%b rgb=%h l=%b id=%0d want v=1 rgb=002a2a l=0 id=0", out_valid_o, out_rgb_o, out_last_o, out_id_o); end
    step(1'b1);
    n_checks++; if ({out_valid_o, out_rgb_o, out_last_o} !== {1'b1, 24'hD2D5FF, 1'b0})
      begin n_fail++; $display("FAIL basic_beat2: got v=%b rgb=%h l=%b want v=1 rgb=d2d5ff l=0", out_valid_o, out_rgb_o, out_last_o); end
    step(1'b1);
    n_checks++; if ({out_valid_o, out_rgb_o, out_last_o, busy_o} !== {1'b1, 24'h081018, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL basic_beat3: got v=%b rgb=%h l=%b busy=%b want v=1 rgb=081018 l=1 busy=0", out_valid_o, out_rgb_o, out_last_o, busy_o); end
    step(1'b1);
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid_o); end
    $display("test_basic_packet done");
  endtask

  task automatic test_round_robin();
    obs_t exp_q [$];
    int lowrun = 0, runs = 0;
    bit started = 0;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 2; k++) push_pkt(k, 2, 1'b0, {8'(k), 8'(p), 8'h5A});
    // Both requesters are always valid, so the grants alternate 0,1,0,1.
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back('{{8'(p % 2), 8'(p / 2), 8'h5A}, 1'b0, p % 2});
      exp_q.push_back('{{8'(p % 2), 8'(p / 2), 8'h5A}, 1'b1, p % 2});
    end
    for (int c = 0; c < 40 && obs_q.size() < 8; c++) begin
      step(1'b1);
      if (busy_o) begin
        if (started && lowrun != 0) begin
          runs++;
          n_checks++; if (lowrun != 1) begin n_fail++; $display("FAIL rr_gap_len: got %0d want 1", lowrun); end
        end
        started = 1;
        lowrun  = 0;
      end else if (started) begin
        lowrun++;
      end
    end
    n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", obs_q.size()); end
    n_checks++; if (runs != 3) begin n_fail++; $display("FAIL rr_gaps: got %0d want 3", runs); end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      n_checks++;
      if (obs_q[i].rgb !== exp_q[i].rgb || obs_q[i].last !== exp_q[i].last || obs_q[i].id != exp_q[i].id) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got rgb=%h l=%b id=%0d want rgb=%h l=%b id=%0d", i,
                 obs_q[i].rgb, obs_q[i].last, obs_q[i].id, exp_q[i].rgb, exp_q[i].last, exp_q[i].id);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    logic [23:0] px [4];
    do_reset();
    for (int b = 0; b < 4; b++) begin
      px[b] = 24'($urandom);
      src_q[0].push_back('{px[b], b == 3, 1'b0, b == 0});
    end
    step(1'b1);
    step(1'b1);
    for (int s = 0; s < 4; s++) begin
      step(1'b0);
      n_checks++;
      if ({out_valid_o, out_rgb_o, out_last_o, 2'(out_id_o), req_ready_o[0]} !== {1'b1, px[0], 1'b0, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b rgb=%h l=%b id=%0d rdy=%b want v=1 rgb=%h l=0 id=0 rdy=0", s,
                 out_valid_o, out_rgb_o, out_last_o, out_id_o, req_ready_o[0], px[0]);
      end
    end
    run_until(4, 30);
    n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      n_checks++;
      if (obs_q[i].rgb !== px[i] || obs_q[i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got rgb=%h l=%b want rgb=%h l=%b", i, obs_q[i].rgb, obs_q[i].last, px[i], i == 3);
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_enable_latch();
    do_reset();
    src_q[1].push_back('{24'h646464, 1'b0, 1'b0, 1'b1});
    src_q[1].push_back('{24'h646464, 1'b0, 1'b1, 1'b0});
    src_q[1].push_back('{24'h646464, 1'b1, 1'b1, 1'b0});
    run_until(3, 20);
    n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL en_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      n_checks++;
      if (obs_q[i].rgb !== 24'h646464 || obs_q[i].id != 1 || obs_q[i].last !== (i == 2)) begin
        n_fail++;
        $display("FAIL en_beat%0d: got rgb=%h id=%0d l=%b want rgb=646464 id=1 l=%b", i,
                 obs_q[i].rgb, obs_q[i].id, obs_q[i].last, i == 2);
      end
    end
    $display("test_enable_latch done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_pkt(0, 1, 1'b0, 24'h000000);        // moves the pointer to 1
    run_until(1, 20);
    obs_q.delete();
    push_pkt(1, 4, 1'b1, 24'h202020);
    for (int c = 0; c < 20 && src_q[1].size() > 2; c++) step(1'b1);
    @(negedge clk);
    rst_i       = 1'b1;
    req_valid_i = '0;
    #1;
    n_checks++;
    if ({out_valid_o, out_last_o, out_rgb_o, busy_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got v=%b l=%b rgb=%h busy=%b rdy=%b want all 0",
               out_valid_o, out_last_o, out_rgb_o, busy_o, req_ready_o);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i].last !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_last: got last=1 on beat %0d want 0", i); end
    end
    @(posedge clk);
    #1;
    n_checks++; if ({out_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_hold: got v=%b busy=%b want 0 0", out_valid_o, busy_o); end
    @(negedge clk);
    for (int k = 0; k < NUM; k++) src_q[k].delete();
    obs_q.delete();
    rst_i = 1'b0;
    push_pkt(0, 1, 1'b0, 24'h111111);
    push_pkt(1, 1, 1'b0, 24'h222222);
    run_until(2, 20);
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL post_reset_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_checks++;
      if (obs_q[0].id != 0 || obs_q[0].rgb !== 24'h111111 || obs_q[1].id != 1) begin
        n_fail++;
        $display("FAIL post_reset_order: got id0=%0d rgb0=%h id1=%0d want id0=0 rgb0=111111 id1=1",
                 obs_q[0].id, obs_q[0].rgb, obs_q[1].id);
      end
    end
    $display("test_mid_reset done");
  endtask

  // Randomized traffic with valid gaps, random downstream stalls and
  // mid-packet enable noise. The reference is a packet-level round-robin
  // scheduler over the requesters that still have packets pending.
  task automatic test_random(input int round);
    obs_t pq [NUM][$];
    obs_t exp_q [$];
    obs_t o;
    int ptr, sel, len, cyc;
    logic en;
    logic [23:0] px;
    do_reset();
    gap_mode = 1;
    for (int k = 0; k < NUM; k++) begin
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
        len = $urandom_range(1, 5);
        en  = 1'($urandom);
        for (int b = 0; b < len; b++) begin
          px = 24'($urandom);
          src_q[k].push_back('{px, b == len - 1, (b == 0) ? en : 1'($urandom), b == 0});
          pq[k].push_back('{ref_px(px, en), b == len - 1, k});
        end
      end
    end
    ptr = 0;
    forever begin
      sel = -1;
      for (int off = NUM - 1; off >= 0; off--)
        if (pq[(ptr + off) % NUM].size() > 0) sel = (ptr + off) % NUM;
      if (sel < 0) break;
      do begin
        o = pq[sel].pop_front();
        exp_q.push_back(o);
      end while (!o.last);
      ptr = (sel + 1) % NUM;
    end
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 3000) begin
      step($urandom_range(3) != 0);
      cyc++;
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand%0d_count: got %0d want %0d", round, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].rgb !== exp_q[i].rgb || obs_q[i].last !== exp_q[i].last || obs_q[i].id != exp_q[i].id) begin
        n_fail++;
        $display("FAIL rand%0d_beat%0d: got rgb=%h l=%b id=%0d want rgb=%h l=%b id=%0d", round, i,
                 obs_q[i].rgb, obs_q[i].last, obs_q[i].id, exp_q[i].rgb, exp_q[i].last, exp_q[i].id);
      end
    end
    $display("test_random round %0d: %0d beats", round, exp_q.size());
  endtask

`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
  task automatic test_pkt_cnt();
    int prev;
    do_reset();
    for (int p = 0; p < 5; p++) push_pkt(0, 1, 1'b0, 24'(p));
    for (int c = 0; c < 40 && obs_q.size() < 5; c++) begin
      prev = obs_q.size();
      step(1'b1);
      if (obs_q.size() > prev) begin
        n_checks++;
        if (pkt_cnt_o !== CNT_W'(obs_q.size())) begin
          n_fail++;
          $display("FAIL pkt_cnt_%0d: got %0d want %0d", obs_q.size(), pkt_cnt_o, obs_q.size() % (1 << CNT_W));
        end
      end
    end
    n_checks++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL pkt_cnt_total: got %0d want 5", obs_q.size()); end
    $display("test_pkt_cnt done");
  endtask
`endif

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    req_last_i   = '0;
    req_adj_en_i = '0;
    req_rgb_i    = '0;
    out_ready_i  = 1'b0;
    test_reset();
    test_basic_packet();
    test_round_robin();
    test_backpressure();
    test_enable_latch();
    test_mid_reset();
    for (int r = 0; r < 3; r++) test_random(r);
`ifdef RGB_ADJ_ARBITER_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
